// File: rtl/goertzel_bin.sv
`timescale 1ns/1ps
// Single-bin Goertzel detector: runs the second-order recurrence over blocks of
// N samples, then a 3-stage pipeline turns the final state into block power.
module goertzel_bin #(
  parameter int                 N     = 205,
  parameter logic signed [15:0] COEFF = 16'sd27980
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        sample_valid,
  input  logic [15:0] sample,
  output logic [63:0] power,
  output logic        advance,
  output logic        overflow,
  output logic        busy
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  function automatic logic signed [31:0] sat32(input logic signed [33:0] v);
    if (v[33:31] == 3'b000 || v[33:31] == 3'b111) return v[31:0];
    else if (v[33])                                return 32'sh8000_0000;
    else                                           return 32'sh7fff_ffff;
  endfunction

  function automatic logic ovf34(input logic signed [33:0] v);
    return !(v[33:31] == 3'b000 || v[33:31] == 3'b111);
  endfunction

  logic signed [31:0] s1, s2;
  logic [CW-1:0]      cnt;
  logic               ovf_acc;

  logic signed [15:0] sample_s;
  logic signed [47:0] t_prod, t_shf;
  logic signed [33:0] s0_wide;
  logic signed [31:0] s0;
  logic               s0_ovf, accept, last;

  always_comb begin
    sample_s = $signed(sample);
    t_prod   = 48'(COEFF) * 48'(s1);
    t_shf    = t_prod >>> 14;
    s0_wide  = 34'(sample_s) + 34'(t_shf) - 34'(s2);
    s0       = sat32(s0_wide);
    s0_ovf   = ovf34(s0_wide);
    accept   = sample_valid && !clear;
    last     = (cnt == CW'(N - 1));
  end

  assign busy = (cnt != '0);

  // Snapshot of the finished block, so the recurrence can restart at once.
  logic               snap_v, snap_ovf;
  logic signed [31:0] snap_s1, snap_s2;

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent logic.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1       <= '0;
      s2       <= '0;
      cnt      <= '0;
      ovf_acc  <= 1'b0;
      snap_v   <= 1'b0;
      snap_s1  <= '0;
      snap_s2  <= '0;
      snap_ovf <= 1'b0;
    end else begin
      snap_v <= accept && last;
      if (clear) begin
        s1      <= '0;
        s2      <= '0;
        cnt     <= '0;
        ovf_acc <= 1'b0;
      end else if (sample_valid) begin
        if (last) begin
          snap_s1  <= s0;
          snap_s2  <= s1;
          snap_ovf <= ovf_acc | s0_ovf;
          s1       <= '0;
          s2       <= '0;
          cnt      <= '0;
          ovf_acc  <= 1'b0;
        end else begin
          s1      <= s0;
          s2      <= s1;
          cnt     <= cnt + 1'b1;
          ovf_acc <= ovf_acc | s0_ovf;
        end
      end
    end
  end

  // Stage 1: the three 64-bit products.
  logic signed [47:0] c_prod, c_shf;
  logic signed [31:0] c_t;
  logic               c_ovf;

  always_comb begin
    c_prod = 48'(COEFF) * 48'(snap_s1);
    c_shf  = c_prod >>> 14;
    c_t    = sat32(34'(c_shf));
    c_ovf  = ovf34(34'(c_shf));
  end

  logic               st1_v, st1_ovf;
  logic signed [63:0] p1, p2, cc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st1_v   <= 1'b0;
      st1_ovf <= 1'b0;
      p1      <= '0;
      p2      <= '0;
      cc      <= '0;
    end else begin
      st1_v <= snap_v;
      if (snap_v) begin
        p1      <= 64'(snap_s1) * 64'(snap_s1);
        p2      <= 64'(snap_s2) * 64'(snap_s2);
        cc      <= 64'(c_t) * 64'(snap_s2);
        st1_ovf <= snap_ovf | c_ovf;
      end
    end
  end

  // Stage 2: combine, saturate to 64 bits, then clamp negatives to zero.
  logic signed [65:0] sum;
  logic signed [63:0] sum_sat;
  logic               sum_ovf;

  always_comb begin
    sum     = 66'(p1) + 66'(p2) - 66'(cc);
    sum_ovf = !(sum[65:63] == 3'b000 || sum[65:63] == 3'b111);
    if (!sum_ovf)    sum_sat = sum[63:0];
    else if (sum[65]) sum_sat = 64'sh8000_0000_0000_0000;
    else             sum_sat = 64'sh7fff_ffff_ffff_ffff;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      power    <= '0;
      overflow <= 1'b0;
      advance  <= 1'b0;
    end else begin
      advance <= st1_v;
      if (st1_v) begin
        power    <= sum_sat[63] ? 64'd0 : sum_sat;
        overflow <= st1_ovf | sum_ovf;
      end
    end
  end

endmodule

// File: tb/tb_goertzel_bin.sv
`timescale 1ns/1ps
// Scoreboard bench for goertzel_bin: four instances with different N/COEFF run
// in parallel; drivers push expected blocks, a negedge monitor pops and compares.
module tb_goertzel_bin;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst_v   [4];
  logic        clr_v   [4];
  logic        valid_v [4];
  logic [15:0] smp     [4];
  logic [63:0] pw      [4];
  logic        adv_v   [4];
  logic        ovf_v   [4];
  logic        busy_v  [4];

  goertzel_bin #(.N(4),   .COEFF(16'sd0)) u_a (
    .clk(clk), .reset(rst_v[0]), .clear(clr_v[0]), .sample_valid(valid_v[0]), .sample(smp[0]),
    .power(pw[0]), .advance(adv_v[0]), .overflow(ovf_v[0]), .busy(busy_v[0]));
  goertzel_bin #(.N(205), .COEFF(16'sd32767)) u_b (
    .clk(clk), .reset(rst_v[1]), .clear(clr_v[1]), .sample_valid(valid_v[1]), .sample(smp[1]),
    .power(pw[1]), .advance(adv_v[1]), .overflow(ovf_v[1]), .busy(busy_v[1]));
  goertzel_bin u_c (
    .clk(clk), .reset(rst_v[2]), .clear(clr_v[2]), .sample_valid(valid_v[2]), .sample(smp[2]),
    .power(pw[2]), .advance(adv_v[2]), .overflow(ovf_v[2]), .busy(busy_v[2]));
  goertzel_bin #(.N(512), .COEFF(-16'sd32768)) u_d (
    .clk(clk), .reset(rst_v[3]), .clear(clr_v[3]), .sample_valid(valid_v[3]), .sample(smp[3]),
    .power(pw[3]), .advance(adv_v[3]), .overflow(ovf_v[3]), .busy(busy_v[3]));

  typedef struct {
    int          id;
    logic [63:0] pw;
    logic        ov;
    int          cyc;
  } exp_t;

  exp_t sbq[$];
  int   n_vec = 0;
  int   n_mis = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, got, got, exp, exp);
    end
  endtask

  // Reference model of the recurrence and power formula, one state set per instance.
  localparam longint MAX32 = 64'sd2147483647;
  localparam longint MIN32 = -64'sd2147483648;
  longint ms1 [4];
  longint ms2 [4];
  bit     movf[4];
  int     mcnt[4];

  function automatic longint coef(input int i);
    case (i)
      0:       return 0;
      1:       return 32767;
      2:       return 27980;
      default: return -32768;
    endcase
  endfunction

  function automatic int nblk(input int i);
    case (i)
      0:       return 4;
      3:       return 512;
      default: return 205;
    endcase
  endfunction

  function automatic void mreset(input int i);
    ms1[i] = 0; ms2[i] = 0; movf[i] = 0; mcnt[i] = 0;
  endfunction

  function automatic void mstep(input int i, input logic signed [15:0] x);
    longint t, s0, ct;
    logic signed [65:0] a, a1, a2, a3, mx, mn;
    bit ov;
    t  = (coef(i) * ms1[i]) >>> 14;
    s0 = longint'(x) + t - ms2[i];
    if (s0 > MAX32)      begin s0 = MAX32; movf[i] = 1; end
    else if (s0 < MIN32) begin s0 = MIN32; movf[i] = 1; end
    ms2[i] = ms1[i];
    ms1[i] = s0;
    mcnt[i]++;
    if (mcnt[i] == nblk(i)) begin
      ov = movf[i];
      ct = (coef(i) * ms1[i]) >>> 14;
      if (ct > MAX32)      begin ct = MAX32; ov = 1; end
      else if (ct < MIN32) begin ct = MIN32; ov = 1; end
      a1 = ms1[i] * ms1[i];
      a2 = ms2[i] * ms2[i];
      a3 = ct * ms2[i];
      a  = a1 + a2 - a3;
      mx = 66'sd9223372036854775807;
      mn = -mx - 66'sd1;
      if (a > mx)      begin a = mx; ov = 1; end
      else if (a < mn) begin a = mn; ov = 1; end
      if (a < 0) a = 0;
      sbq.push_back('{id: i, pw: a[63:0], ov: ov, cyc: cyc + 3});
      mreset(i);
    end
  endfunction

  // One cycle of stimulus on instance i, then a busy check against the model count.
  task automatic apply(input int i, input bit v, input logic [15:0] x, input bit clr);
    valid_v[i] = v;
    smp[i]     = x;
    clr_v[i]   = clr;
    if (clr)    mreset(i);
    else if (v) mstep(i, x);
    @(posedge clk); #1;
    check($sformatf("u%0d busy @%0d", i, cyc), 64'(busy_v[i]), 64'(mcnt[i] != 0));
    valid_v[i] = 1'b0;
    clr_v[i]   = 1'b0;
  endtask

  task automatic idle(input int i, input int n);
    repeat (n) apply(i, 1'b0, 16'h5a5a, 1'b0);
  endtask

  task automatic seq_a();
    int pat_a[4] = '{1, 0, -1, 0};
    int pat_b[4] = '{1, 1, 1, 1};
    for (int k = 0; k < 4; k++) apply(0, 1'b1, 16'(pat_a[k]), 1'b0);
    idle(0, 5);
    for (int k = 0; k < 4; k++) apply(0, 1'b1, 16'(pat_b[k]), 1'b0);
    for (int k = 0; k < 4; k++) apply(0, 1'b1, 16'(pat_a[k]), 1'b0);
    idle(0, 5);
    // Partial block aborted by reset.
    apply(0, 1'b1, 16'd1, 1'b0);
    apply(0, 1'b1, 16'd0, 1'b0);
    rst_v[0] = 1'b0;
    mreset(0);
    @(posedge clk); #1;
    check("u0 busy in reset", 64'(busy_v[0]), 64'd0);
    check("u0 power in reset", pw[0], 64'd0);
    rst_v[0] = 1'b1;
    for (int k = 0; k < 4; k++) apply(0, 1'b1, 16'(pat_a[k]), 1'b0);
    idle(0, 5);
    // Mid-block clear with a sample present, then clear right after a block end.
    apply(0, 1'b1, 16'd1, 1'b0);
    apply(0, 1'b1, 16'd1, 1'b0);
    apply(0, 1'b1, 16'd5, 1'b1);
    for (int k = 0; k < 4; k++) apply(0, 1'b1, 16'(pat_a[k]), 1'b0);
    apply(0, 1'b1, 16'h7fff, 1'b1);
    for (int k = 0; k < 4; k++) apply(0, 1'b1, 16'(pat_a[k]), 1'b0);
    // Gaps with valid low must hold state.
    apply(0, 1'b1, 16'd1, 1'b0);
    idle(0, 2);
    apply(0, 1'b1, 16'd0, 1'b0);
    idle(0, 1);
    apply(0, 1'b1, 16'hffff, 1'b0);
    apply(0, 1'b1, 16'd0, 1'b0);
    idle(0, 5);
  endtask

  task automatic seq_b();
    repeat (205) apply(1, 1'b1, 16'sd32767, 1'b0);
    repeat (205) apply(1, 1'b1, 16'd0, 1'b0);
    idle(1, 5);
  endtask

  task automatic seq_c();
    int acc = 0;
    while (acc < 4 * 205) begin
      if ($urandom_range(0, 2) != 0) begin
        apply(2, 1'b1, 16'($urandom), 1'b0);
        acc++;
      end else begin
        apply(2, 1'b0, 16'($urandom), 1'b0);
      end
    end
    idle(2, 5);
  endtask

  task automatic seq_d();
    for (int k = 0; k < 512; k++) apply(3, 1'b1, (k % 2 != 0) ? -16'sd32767 : 16'sd32767, 1'b0);
    repeat (512) apply(3, 1'b1, 16'd0, 1'b0);
    idle(3, 5);
  endtask

  // Monitor: every advance must match the oldest expected block of that instance.
  always @(negedge clk) begin
    int   idx[$];
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      if (adv_v[i] === 1'b1) begin
        idx = sbq.find_first_index(x) with (x.id == i);
        if (idx.size() == 0) begin
          n_vec++;
          n_mis++;
          $display("FAIL u%0d unexpected advance @%0d: got power %0d, required no advance", i, cyc, pw[i]);
        end else begin
          e = sbq[idx[0]];
          sbq.delete(idx[0]);
          check($sformatf("u%0d power", i), pw[i], e.pw);
          check($sformatf("u%0d overflow", i), 64'(ovf_v[i]), 64'(e.ov));
          check($sformatf("u%0d advance cycle", i), 64'(cyc), 64'(e.cyc));
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 4; i++) begin
      rst_v[i] = 1'b0; clr_v[i] = 1'b0; valid_v[i] = 1'b0; smp[i] = 16'h1111;
      mreset(i);
    end
    repeat (3) @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("u%0d reset power", i),    pw[i], 64'd0);
      check($sformatf("u%0d reset advance", i),  64'(adv_v[i]), 64'd0);
      check($sformatf("u%0d reset overflow", i), 64'(ovf_v[i]), 64'd0);
      check($sformatf("u%0d reset busy", i),     64'(busy_v[i]), 64'd0);
      rst_v[i] = 1'b1;
    end
    fork
      seq_a();
      seq_b();
      seq_c();
      seq_d();
    join
    repeat (8) @(posedge clk); #1;
    check("scoreboard drained", 64'(sbq.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within 200000 ns");
    $fatal(1);
  end

endmodule

// File: doc/goertzel_bin.md
GOERTZEL_BIN -- requirements
Module: goertzel_bin

Interface
REQ-001 Parameter N, default 205: samples per Goertzel block, 2..4095.
REQ-002 Parameter COEFF, default 16'sd27980: signed Q2.14 value of 2cos(2*pi*k/N).
REQ-003 clk  input  1  single clock; all logic is rising-edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 clear  input  1  synchronous block abort.
REQ-006 sample_valid  input  1  sample qualifier; at most one sample per cycle.
REQ-007 sample  input  16  signed audio sample.
REQ-008 power  output  64  signed block power, held until the next update.
REQ-009 advance  output  1  one-cycle pulse; power and overflow are new this cycle.
REQ-010 overflow  output  1  saturation occurred in the block that produced the current power.
REQ-011 busy  output  1  high while the current block holds at least one accepted sample.

Function
REQ-012 State regs s1, s2 SHALL be signed 32-bit; the sample counter cnt SHALL run 0..N-1.
REQ-013 On each accepted sample, the recurrence SHALL be: t = (COEFF*s1) >>> 14 (48-bit product, arithmetic shift); s0 = sample + t - s2 (34-bit); s0 saturates to 32-bit signed; then s2<=s1, s1<=s0, cnt<=cnt+1.
REQ-014 Any saturation in REQ-013 SHALL set the sticky block flag ovf_acc.
REQ-015 When the sample with cnt==N-1 is accepted, the block SHALL:
- snapshot the post-update s1, s2 and ovf_acc into stage-1 regs;
- clear s1, s2, cnt and ovf_acc in the same cycle;
- accept the next sample on the following cycle with no gap.
REQ-016 Stage 1 (1 cycle after snapshot) SHALL compute:
- p1 = s1*s1 and p2 = s2*s2 (64-bit);
- c = ((COEFF*s1)>>>14, saturated to 32-bit) * s2 (64-bit);
- c saturation ORs into the carried overflow flag.
REQ-017 Stage 2 SHALL compute p1+p2-c in 66 bits, then:
- saturate the result to 64-bit signed;
- clamp a negative result to 0;
- register it to power with overflow, and pulse advance.
REQ-018 Latency SHALL be fixed: advance is high exactly 3 clk cycles after the cycle in which the Nth sample is accepted.
REQ-019 The power pipeline SHALL be fully pipelined: blocks ending on consecutive cycles (N small) each produce their own advance pulse.
REQ-020 clear SHALL zero s1, s2, cnt and ovf_acc, discarding any sample presented in the same cycle.
REQ-021 clear SHALL NOT cancel a block already snapshotted; its advance still fires.
REQ-022 sample is ignored when sample_valid is low; s1, s2 and cnt hold.
REQ-023 busy SHALL equal (cnt != 0).
REQ-024 A power value below 2^63 with no saturation SHALL be bit-exact to the integer formula in REQ-013/016/017.

Reset
REQ-025 While reset is low, the following SHALL be 0: s1, s2, cnt, ovf_acc, all pipeline regs, power, advance, overflow and busy.
REQ-026 Reset low at any point SHALL abort the partial block and all in-flight pipeline results; no advance fires for them.
REQ-027 After reset deassertion, a full N accepted samples SHALL be required before the next advance.

Verification
REQ-028 COEFF=0, N=4, samples 1,0,-1,0 on consecutive cycles -> advance 3 cycles after the 4th sample, power=4, overflow=0.
REQ-029 COEFF=0, N=4, samples 1,1,1,1 -> power=0; then samples 1,0,-1,0 back-to-back with no gap -> second advance exactly 4 cycles after the first, power=4.
REQ-030 N=4, samples 1,0 then reset low for 1 cycle, then 1,0,-1,0 -> exactly one advance, power=4.
REQ-031 COEFF=32767, N=205, sample=32767 every cycle -> overflow=1 at advance and power saturated, non-negative; the next block of zeros -> power=0, overflow=0.
REQ-032 Default parameters, sample_valid toggled randomly -> power matches a bit-accurate reference model for every block; busy drops to 0 on each block boundary.
REQ-033 clear asserted 1 cycle after the Nth sample -> that block's advance still fires; the next block restarts from cnt=0 and ignores the sample presented with clear.
